// File: rtl/apb_master_fsm.sv
// rtl/apb_master_fsm.sv - APB master sequencer (IDLE/SETUP/ACCESS/RESP) for the AXI2APB bridge
// Optional feature: define APB_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT_CYCLES cycles.

module apb_master_fsm #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [ADDR_WIDTH-1:0]   req_addr_i,
   input  logic                    req_write_i,
   input  logic [DATA_WIDTH-1:0]   req_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] req_strb_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic [ADDR_WIDTH-1:0]   dec_addr_o,
   input  logic [1:0]              dec_psel_i,
   output logic [ADDR_WIDTH-1:0]   paddr_o,
   output logic                    pwrite_o,
   output logic [DATA_WIDTH-1:0]   pwdata_o,
   output logic [DATA_WIDTH/8-1:0] pstrb_o,
   output logic [1:0]              psel_o,
   output logic                    penable_o,
   input  logic [DATA_WIDTH-1:0]   prdata1_i,
   input  logic                    pready1_i,
   input  logic                    pslverr1_i,
   input  logic [DATA_WIDTH-1:0]   prdata2_i,
   input  logic                    pready2_i,
   input  logic                    pslverr2_i
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t                  state;
   state_t                  state_nxt;

   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    write_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [STRB_WIDTH-1:0]   strb_q;
   logic [1:0]              sel_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    err_q;

   logic                    sel_ok;
   logic                    pready_sel;
   logic                    pslverr_sel;
   logic [DATA_WIDTH-1:0]   prdata_sel;
   logic                    timeout_hit;

   // Only a one-hot decoder result selects a slave; 00 and 11 are decode errors.
   assign sel_ok = (dec_psel_i == 2'b01) || (dec_psel_i == 2'b10);

   // The latched select steers the response mux so the idle slave is never observed.
   assign pready_sel  = sel_q[1] ? pready2_i  : pready1_i;
   assign pslverr_sel = sel_q[1] ? pslverr2_i : pslverr1_i;
   assign prdata_sel  = sel_q[1] ? prdata2_i  : prdata1_i;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CNT_W-1:0] tmo_cnt;

   // Count ACCESS cycles; cleared while in SETUP so each transfer starts from zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tmo_cnt <= '0;
      end else if (state == SETUP) begin
         tmo_cnt <= '0;
      end else if (state == ACCESS) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   // Last allowed ACCESS cycle without pready ends the transfer; pready in that cycle still wins.
   assign timeout_hit = (state == ACCESS) && !pready_sel &&
                        (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

   assign timeout_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and per-state handshake/APB control outputs.
   always_comb begin
      state_nxt   = state;
      req_ready_o = 1'b0;
      psel_o      = 2'b00;
      penable_o   = 1'b0;
      rsp_valid_o = 1'b0;
      case (state)
         IDLE: begin
            req_ready_o = !rst_i;
            if (req_valid_i) begin
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            psel_o    = sel_ok ? dec_psel_i : 2'b00;
            state_nxt = sel_ok ? ACCESS : RESP;
         end
         ACCESS: begin
            psel_o    = sel_q;
            penable_o = 1'b1;
            if (pready_sel || timeout_hit) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Request, select and response registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
         sel_q   <= 2'b00;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (state == IDLE && req_valid_i) begin
            addr_q  <= req_addr_i;
            write_q <= req_write_i;
            wdata_q <= req_write_i ? req_wdata_i : '0;
            strb_q  <= req_write_i ? req_strb_i  : '0;
         end
         if (state == SETUP) begin
            sel_q <= sel_ok ? dec_psel_i : 2'b00;
            if (!sel_ok) begin
               err_q   <= 1'b1;
               rdata_q <= '0;
            end
         end
         if (state == ACCESS) begin
            if (pready_sel) begin
               err_q   <= pslverr_sel;
               rdata_q <= write_q ? '0 : prdata_sel;
            end else if (timeout_hit) begin
               err_q   <= 1'b1;
               rdata_q <= '0;
            end
         end
      end
   end

   // APB request lines come straight from the request register, so they are stable across SETUP/ACCESS.
   assign dec_addr_o  = addr_q;
   assign paddr_o     = addr_q;
   assign pwrite_o    = write_q;
   assign pwdata_o    = wdata_q;
   assign pstrb_o     = strb_q;

   // Response payload is only presented while the response is valid.
   assign rsp_rdata_o = (state == RESP) ? rdata_q : '0;
   assign rsp_err_o   = (state == RESP) ? err_q   : 1'b0;

endmodule

// File: tb/tb_apb_master_fsm.sv
// tb/tb_apb_master_fsm.sv - randomized self-checking bench for apb_master_fsm against a transaction-level model

module tb_apb_master_fsm;

   localparam int TMO = 8;
`ifdef APB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_write;
   logic [31:0] req_wdata;
   logic [3:0]  req_strb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] dec_addr;
   logic [1:0]  dec_psel;
   logic [31:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [1:0]  psel;
   logic        penable;
   logic [31:0] prdata1;
   logic        pready1;
   logic        pslverr1;
   logic [31:0] prdata2;
   logic        pready2;
   logic        pslverr2;

   logic        force_dec;
   logic [1:0]  force_val;

   int vectors;
   int miscompares;

   int          obs_lat;
   int          obs_access;
   int          obs_proto_bad;
   int          obs_apb_bad;
   int          obs_hold_bad;
   logic        obs_idle_ok;
   logic        obs_accept_ok;
   logic [31:0] obs_rdata;
   logic        obs_err;

   int          exp_lat;
   int          exp_access;
   logic [31:0] exp_rdata;
   logic        exp_err;

   apb_master_fsm #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_addr_i  (req_addr),
      .req_write_i (req_write),
      .req_wdata_i (req_wdata),
      .req_strb_i  (req_strb),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .dec_addr_o  (dec_addr),
      .dec_psel_i  (dec_psel),
      .paddr_o     (paddr),
      .pwrite_o    (pwrite),
      .pwdata_o    (pwdata),
      .pstrb_o     (pstrb),
      .psel_o      (psel),
      .penable_o   (penable),
      .prdata1_i   (prdata1),
      .pready1_i   (pready1),
      .pslverr1_i  (pslverr1),
      .prdata2_i   (prdata2),
      .pready2_i   (pready2),
      .pslverr2_i  (pslverr2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Address map of the bridge decoder.
   function automatic logic [1:0] ref_decode(input logic [31:0] a);
      if (a >= 32'h0001_F000 && a <= 32'h0001_FFFF) return 2'b01;
      if (a >= 32'h0002_F000 && a <= 32'h0002_FFFF) return 2'b10;
      return 2'b00;
   endfunction

   assign dec_psel = force_dec ? force_val : ref_decode(dec_addr);

   function automatic logic rbit();
      return ($urandom & 32'd1) == 32'd1;
   endfunction

   // Transaction-level expectation: latency from accept edge, ACCESS length, response payload.
   task automatic ref_xfer(input logic [31:0] addr, input logic wr, input logic fdec,
                           input logic [1:0] fval, input int waits, input logic serr,
                           input logic [31:0] rd);
      logic [1:0] s;
      logic       ok;
      logic       tmo;
      s   = fdec ? fval : ref_decode(addr);
      ok  = (s == 2'b01) || (s == 2'b10);
      tmo = ok && TMO_EN && (waits >= TMO);
      if (!ok) begin
         exp_lat = 2; exp_access = 0; exp_err = 1'b1; exp_rdata = 32'h0;
      end else if (tmo) begin
         exp_lat = 2 + TMO; exp_access = TMO; exp_err = 1'b1; exp_rdata = 32'h0;
      end else begin
         exp_lat = 3 + waits; exp_access = waits + 1; exp_err = serr;
         exp_rdata = wr ? 32'h0 : rd;
      end
   endtask

   // Drives one request plus the slave side cycle by cycle and records what the DUT did.
   task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                           input logic [3:0] st, input logic fdec, input logic [1:0] fval,
                           input int waits, input logic serr, input logic [31:0] rd,
                           input int hold, input logic stray);
      logic [1:0]  s;
      logic        ok;
      logic [31:0] ex_wd;
      logic [3:0]  ex_st;
      logic        done;
      logic        seen;
      logic        hs;
      int          v;
      logic [31:0] r0;
      logic        e0;
      s     = fdec ? fval : ref_decode(addr);
      ok    = (s == 2'b01) || (s == 2'b10);
      ex_wd = wr ? wd : 32'h0;
      ex_st = wr ? st : 4'h0;
      obs_lat = -1; obs_access = 0; obs_proto_bad = 0; obs_apb_bad = 0; obs_hold_bad = 0;
      obs_idle_ok = 1'b0; obs_rdata = 32'hX; obs_err = 1'bX;
      done = 1'b0; seen = 1'b0; hs = 1'b0; v = 0; r0 = 32'h0; e0 = 1'b0;
      @(posedge clk); #1;
      force_dec = fdec; force_val = fval;
      req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wd; req_strb = st;
      rsp_ready = 1'b0;
      @(negedge clk);
      obs_accept_ok = (req_ready === 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = $urandom; req_write = rbit(); req_wdata = $urandom;
      req_strb = 4'($urandom_range(0, 15));
      for (int k = 1; k <= 40 && !done; k++) begin
         if (k > 1) begin
            @(posedge clk); #1;
         end
         prdata1 = $urandom; pslverr1 = rbit(); pready1 = stray | rbit();
         prdata2 = $urandom; pslverr2 = rbit(); pready2 = stray | rbit();
         if (s == 2'b01) begin
            pready1 = (k == waits + 2) || (k == 1 && rbit());
            if (k == waits + 2) begin pslverr1 = serr; prdata1 = rd; end
         end else if (s == 2'b10) begin
            pready2 = (k == waits + 2) || (k == 1 && rbit());
            if (k == waits + 2) begin pslverr2 = serr; prdata2 = rd; end
         end
         @(negedge clk);
         if (hs) begin
            obs_idle_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1) && (psel === 2'b00);
            rsp_ready = 1'b0;
            done = 1'b1;
         end else begin
            if (!seen && rsp_valid === 1'b1) begin
               seen = 1'b1; obs_lat = k; r0 = rsp_rdata; e0 = rsp_err;
               obs_rdata = rsp_rdata; obs_err = rsp_err;
            end
            if (seen) begin
               if (rsp_valid !== 1'b1 || rsp_rdata !== r0 || rsp_err !== e0 || req_ready !== 1'b0)
                  obs_hold_bad++;
               if (psel !== 2'b00 || penable !== 1'b0) obs_proto_bad++;
               if (v >= hold) begin
                  rsp_ready = 1'b1; hs = 1'b1;
               end
               v++;
            end else begin
               if (req_ready !== 1'b0) obs_proto_bad++;
               if (k == 1) begin
                  if (psel !== (ok ? s : 2'b00) || penable !== 1'b0) obs_proto_bad++;
               end else begin
                  if (psel !== s || penable !== 1'b1) obs_proto_bad++;
                  obs_access++;
               end
               if (paddr !== addr || pwrite !== wr || pwdata !== ex_wd || pstrb !== ex_st ||
                   dec_addr !== addr) obs_apb_bad++;
            end
         end
      end
      rsp_ready = 1'b0;
      force_dec = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
      vectors++;
      if (psel !== 2'b00 || penable !== 1'b0 || rsp_valid !== 1'b0) begin
         miscompares++; $display("FAIL rst_ctrl: psel=%b penable=%b rsp_valid=%b want 00/0/0", psel, penable, rsp_valid);
      end
      vectors++;
      if (dec_addr !== 32'h0 || paddr !== 32'h0 || pwdata !== 32'h0 || pstrb !== 4'h0 || pwrite !== 1'b0) begin
         miscompares++; $display("FAIL rst_apb: dec_addr=%h paddr=%h pwdata=%h pstrb=%h want 0", dec_addr, paddr, pwdata, pstrb);
      end
      vectors++;
      if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
         miscompares++; $display("FAIL rst_rsp: rdata=%h err=%b want 0/0", rsp_rdata, rsp_err);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_write_slv1();
      ref_xfer(32'h0001_F004, 1'b1, 1'b0, 2'b00, 0, 1'b0, 32'h0);
      run_xfer(32'h0001_F004, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 2'b00, 0, 1'b0, 32'h0, 0, 1'b0);
      vectors++;
      if (obs_lat !== exp_lat) begin miscompares++; $display("FAIL wr1_latency: got %0d want %0d", obs_lat, exp_lat); end
      vectors++;
      if (obs_err !== exp_err || obs_rdata !== exp_rdata) begin
         miscompares++; $display("FAIL wr1_rsp: err=%b rdata=%h want %b/%h", obs_err, obs_rdata, exp_err, exp_rdata);
      end
      vectors++;
      if (obs_access !== exp_access || obs_proto_bad !== 0 || obs_apb_bad !== 0 || obs_idle_ok !== 1'b1 || obs_accept_ok !== 1'b1) begin
         miscompares++; $display("FAIL wr1_protocol: access=%0d/%0d proto=%0d apb=%0d idle=%b accept=%b want %0d/0/0/1/1",
                                 obs_access, exp_access, obs_proto_bad, obs_apb_bad, obs_idle_ok, obs_accept_ok, exp_access);
      end
   endtask

   task automatic test_read_wait_slv2();
      ref_xfer(32'h0002_F010, 1'b0, 1'b0, 2'b00, 3, 1'b0, 32'h1234_5678);
      run_xfer(32'h0002_F010, 1'b0, 32'hAAAA_5555, 4'hF, 1'b0, 2'b00, 3, 1'b0, 32'h1234_5678, 0, 1'b0);
      vectors++;
      if (obs_lat !== 6 || obs_lat !== exp_lat) begin miscompares++; $display("FAIL rd2_latency: got %0d want %0d", obs_lat, exp_lat); end
      vectors++;
      if (obs_rdata !== exp_rdata || obs_err !== exp_err) begin
         miscompares++; $display("FAIL rd2_rsp: rdata=%h err=%b want %h/%b", obs_rdata, obs_err, exp_rdata, exp_err);
      end
      vectors++;
      if (obs_access !== 4 || obs_proto_bad !== 0 || obs_apb_bad !== 0 || obs_idle_ok !== 1'b1) begin
         miscompares++; $display("FAIL rd2_protocol: access=%0d proto=%0d apb=%0d idle=%b want 4/0/0/1",
                                 obs_access, obs_proto_bad, obs_apb_bad, obs_idle_ok);
      end
   endtask

   task automatic test_slverr();
      ref_xfer(32'h0001_F3FC, 1'b0, 1'b0, 2'b00, 1, 1'b1, 32'hCAFE_0001);
      run_xfer(32'h0001_F3FC, 1'b0, 32'h0, 4'h0, 1'b0, 2'b00, 1, 1'b1, 32'hCAFE_0001, 1, 1'b0);
      vectors++;
      if (obs_err !== 1'b1 || obs_rdata !== 32'hCAFE_0001) begin
         miscompares++; $display("FAIL slverr_rsp: err=%b rdata=%h want 1/cafe0001", obs_err, obs_rdata);
      end
      vectors++;
      if (obs_lat !== exp_lat || obs_hold_bad !== 0) begin
         miscompares++; $display("FAIL slverr_timing: lat=%0d hold=%0d want %0d/0", obs_lat, obs_hold_bad, exp_lat);
      end
   endtask

   task automatic test_decode_err();
      ref_xfer(32'h0001_F008, 1'b1, 1'b1, 2'b00, 0, 1'b0, 32'h0);
      run_xfer(32'h0001_F008, 1'b1, 32'h1111_2222, 4'h3, 1'b1, 2'b00, 0, 1'b0, 32'h0, 0, 1'b0);
      vectors++;
      if (obs_lat !== 2 || obs_access !== 0 || obs_proto_bad !== 0) begin
         miscompares++; $display("FAIL decerr00: lat=%0d access=%0d proto=%0d want 2/0/0", obs_lat, obs_access, obs_proto_bad);
      end
      vectors++;
      if (obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
         miscompares++; $display("FAIL decerr00_rsp: err=%b rdata=%h want 1/0", obs_err, obs_rdata);
      end
      ref_xfer(32'h0002_F000, 1'b0, 1'b1, 2'b11, 0, 1'b0, 32'h5);
      run_xfer(32'h0002_F000, 1'b0, 32'h0, 4'h0, 1'b1, 2'b11, 0, 1'b0, 32'h5, 0, 1'b0);
      vectors++;
      if (obs_lat !== exp_lat || obs_access !== 0 || obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_proto_bad !== 0) begin
         miscompares++; $display("FAIL decerr11: lat=%0d access=%0d err=%b rdata=%h proto=%0d want %0d/0/1/0/0",
                                 obs_lat, obs_access, obs_err, obs_rdata, obs_proto_bad, exp_lat);
      end
   endtask

   task automatic test_backpressure();
      ref_xfer(32'h0001_FFF0, 1'b0, 1'b0, 2'b00, 2, 1'b0, 32'h0BAD_F00D);
      run_xfer(32'h0001_FFF0, 1'b0, 32'h0, 4'h0, 1'b0, 2'b00, 2, 1'b0, 32'h0BAD_F00D, 5, 1'b1);
      vectors++;
      if (obs_hold_bad !== 0 || obs_idle_ok !== 1'b1) begin
         miscompares++; $display("FAIL backpressure_hold: hold_bad=%0d idle=%b want 0/1", obs_hold_bad, obs_idle_ok);
      end
      vectors++;
      if (obs_lat !== exp_lat || obs_rdata !== exp_rdata || obs_err !== exp_err || obs_access !== exp_access) begin
         miscompares++; $display("FAIL backpressure_stray: lat=%0d rdata=%h err=%b access=%0d want %0d/%h/%b/%0d",
                                 obs_lat, obs_rdata, obs_err, obs_access, exp_lat, exp_rdata, exp_err, exp_access);
      end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      pready1 = 1'b0; pready2 = 1'b0;
      req_valid = 1'b1; req_addr = 32'h0001_F100; req_write = 1'b1; req_wdata = 32'h7777_0000; req_strb = 4'h5;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      pready1 = 1'b0; pready2 = 1'b0;
      @(negedge clk);
      vectors++;
      if (penable !== 1'b1 || psel !== 2'b01) begin
         miscompares++; $display("FAIL rstmid_access: psel=%b penable=%b want 01/1", psel, penable);
      end
      #1 rst = 1'b1;
      #1;
      vectors++;
      if (psel !== 2'b00 || penable !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0 || dec_addr !== 32'h0) begin
         miscompares++; $display("FAIL rstmid_async: psel=%b penable=%b rsp_valid=%b req_ready=%b dec_addr=%h want 00/0/0/0/0",
                                 psel, penable, rsp_valid, req_ready, dec_addr);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1 || psel !== 2'b00 || rsp_valid !== 1'b0) begin
         miscompares++; $display("FAIL rstmid_release: req_ready=%b psel=%b rsp_valid=%b want 1/00/0", req_ready, psel, rsp_valid);
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic        wr;
      logic        fdec;
      logic [1:0]  fval;
      int          waits;
      logic        serr;
      logic [31:0] rd;
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 2))
            0:       a = 32'h0001_F000 | ($urandom & 32'h0000_0FFC);
            1:       a = 32'h0002_F000 | ($urandom & 32'h0000_0FFC);
            default: a = $urandom;
         endcase
         wr    = rbit();
         fdec  = ($urandom_range(0, 7) == 0);
         fval  = 2'($urandom_range(0, 3));
         waits = $urandom_range(0, 10);
         serr  = rbit();
         rd    = $urandom;
         ref_xfer(a, wr, fdec, fval, waits, serr, rd);
         run_xfer(a, wr, $urandom, 4'($urandom_range(0, 15)), fdec, fval, waits, serr, rd,
                  $urandom_range(0, 3), 1'b0);
         vectors++;
         if (obs_lat !== exp_lat) begin
            miscompares++; $display("FAIL rand%0d_latency: addr=%h got %0d want %0d", t, a, obs_lat, exp_lat);
         end
         vectors++;
         if (obs_rdata !== exp_rdata || obs_err !== exp_err) begin
            miscompares++; $display("FAIL rand%0d_rsp: addr=%h rdata=%h err=%b want %h/%b", t, a, obs_rdata, obs_err, exp_rdata, exp_err);
         end
         vectors++;
         if (obs_access !== exp_access || obs_proto_bad !== 0 || obs_apb_bad !== 0 || obs_hold_bad !== 0 ||
             obs_idle_ok !== 1'b1 || obs_accept_ok !== 1'b1) begin
            miscompares++; $display("FAIL rand%0d_protocol: access=%0d/%0d proto=%0d apb=%0d hold=%0d idle=%b accept=%b",
                                    t, obs_access, exp_access, obs_proto_bad, obs_apb_bad, obs_hold_bad, obs_idle_ok, obs_accept_ok);
         end
      end
   endtask

`ifdef APB_TIMEOUT_EN
   task automatic test_timeout();
      ref_xfer(32'h0002_F020, 1'b0, 1'b0, 2'b00, 30, 1'b0, 32'h9999_9999);
      run_xfer(32'h0002_F020, 1'b0, 32'h0, 4'h0, 1'b0, 2'b00, 30, 1'b0, 32'h9999_9999, 0, 1'b0);
      vectors++;
      if (obs_access !== TMO || obs_lat !== 2 + TMO || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
         miscompares++; $display("FAIL timeout_expire: access=%0d lat=%0d err=%b rdata=%h want %0d/%0d/1/0",
                                 obs_access, obs_lat, obs_err, obs_rdata, TMO, 2 + TMO);
      end
      ref_xfer(32'h0001_F020, 1'b0, 1'b0, 2'b00, TMO - 1, 1'b0, 32'h4242_4242);
      run_xfer(32'h0001_F020, 1'b0, 32'h0, 4'h0, 1'b0, 2'b00, TMO - 1, 1'b0, 32'h4242_4242, 0, 1'b0);
      vectors++;
      if (obs_access !== TMO || obs_err !== 1'b0 || obs_rdata !== 32'h4242_4242 || obs_lat !== exp_lat) begin
         miscompares++; $display("FAIL timeout_last_cycle: access=%0d err=%b rdata=%h lat=%0d want %0d/0/42424242/%0d",
                                 obs_access, obs_err, obs_rdata, obs_lat, TMO, exp_lat);
      end
   endtask
`endif

   initial begin
      vectors = 0; miscompares = 0;
      rst = 1'b1;
      req_valid = 1'b0; req_addr = 32'h0; req_write = 1'b0; req_wdata = 32'h0; req_strb = 4'h0;
      rsp_ready = 1'b0;
      force_dec = 1'b0; force_val = 2'b00;
      prdata1 = 32'h0; pready1 = 1'b0; pslverr1 = 1'b0;
      prdata2 = 32'h0; pready2 = 1'b0; pslverr2 = 1'b0;
      test_reset();
      test_write_slv1();
      test_read_wait_slv2();
      test_slverr();
      test_decode_err();
      test_backpressure();
      test_reset_mid();
      test_random();
`ifdef APB_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
